rr_index_arbiter: RTL and testbench

Round-robin arbiter that picks one of N request lines and presents the winner as a binary index with a valid/ack handshake. It sits directly upstream of the 3-to-8 `decoder`: `gnt_idx` drives the decoder's `i` input, and the decoder's one-hot `o` selects the granted requester. The block holds each grant until the consumer acknowledges it, then advances priority so every requester is eventually served.

---
 rtl/rr_index_arbiter.sv | 129 ++++++++++++
 tb/tb_rr_index_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_index_arbiter.sv
// -----------------------------------------------------------------------------
// rr_index_arbiter
//
// Purpose:
//   Round-robin arbiter over N level-sensitive request lines. The winner is
//   presented as a binary index with a valid/ack handshake, so gnt_idx can
//   drive a one-hot decoder directly. A grant is held (sticky) until the
//   consumer acknowledges it. The ack then moves the rotation pointer to the
//   granted index, so every requester is eventually served.
//
// Parameters:
//   N     number of request lines. Must be a power of two, >= 2.
//   IDXW  index width. Must equal log2(N).
//
// Ports:
//   clk        in   1     rising-edge clock
//   rst        in   1     asynchronous active-high reset
//   req        in   N     request lines, bit k = requester k
//   gnt_ack    in   1     consumer done with current grant (only used in GRANT)
//   gnt_valid  out  1     a grant is being presented
//   gnt_idx    out  IDXW  granted requester index, frozen while gnt_valid=1
//   gnt_cnt    out  8     acknowledged grants, modulo 256
//
// All outputs come straight from flops. There is no combinational path from
// req or gnt_ack to any output.
// -----------------------------------------------------------------------------
module rr_index_arbiter #(
  parameter int unsigned N    = 8,
  parameter int unsigned IDXW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            gnt_ack,
  output logic            gnt_valid,
  output logic [IDXW-1:0] gnt_idx,
  output logic [7:0]      gnt_cnt
);

  localparam int unsigned CNTW = 8;
  // The first search after reset starts at index 0.
  localparam logic [IDXW-1:0] LAST_RST = IDXW'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e            state_q,     state_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic [IDXW-1:0]   gnt_idx_q,   gnt_idx_d;
  logic [IDXW-1:0]   last_q,      last_d;
  logic [CNTW-1:0]   cnt_q,       cnt_d;

  logic              pick_found_c;
  logic [IDXW-1:0]   pick_idx_c;
  logic [IDXW-1:0]   cand_c;

  // Rotating priority search: scan last+1, last+2, ... and take the first set bit.
  // Index arithmetic wraps because N == 2**IDXW. The final step (k == N)
  // lands back on last itself.
  always_comb begin
    pick_found_c = 1'b0;
    pick_idx_c   = '0;
    cand_c       = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand_c = last_q + IDXW'(k);
      if (!pick_found_c && req[cand_c]) begin
        pick_found_c = 1'b1;
        pick_idx_c   = cand_c;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    gnt_valid_d = gnt_valid_q;
    gnt_idx_d   = gnt_idx_q;
    last_d      = last_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        // gnt_ack is ignored here. Only a live request moves the FSM.
        if (pick_found_c) begin
          gnt_idx_d   = pick_idx_c;
          gnt_valid_d = 1'b1;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        // Grant is sticky. req is not looked at until the ack arrives.
        if (gnt_ack) begin
          last_d      = gnt_idx_q;
          cnt_d       = cnt_q + CNTW'(1);
          gnt_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // State register. Reset clears everything at once, dropping any active grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      last_q      <= LAST_RST;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_idx_q   <= gnt_idx_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
    end
  end

  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_cnt   = cnt_q;

endmodule

// File: tb/tb_rr_index_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_index_arbiter
//
// Purpose: directed bench for rr_index_arbiter (N=8). A behavioural model,
// written from the arbitration rules, is compared against the DUT on every
// falling edge. Literal expectations pin the model at key points.
// Inputs change 2 time units after the falling edge, well away from the
// rising edge.
// -----------------------------------------------------------------------------
module tb_rr_index_arbiter;

  localparam int unsigned N    = 8;
  localparam int unsigned IDXW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req = '0;
  logic            gnt_ack = 1'b0;
  logic            gnt_valid;
  logic [IDXW-1:0] gnt_idx;
  logic [7:0]      gnt_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  rr_index_arbiter #(.N(N), .IDXW(IDXW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt_ack   (gnt_ack),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .gnt_cnt   (gnt_cnt)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  int m_valid = 0;
  int m_idx   = 0;
  int m_cnt   = 0;
  int m_last  = N - 1;

  // First requester found walking forward from the one after 'last'.
  function automatic int rr_pick(input int last, input logic [N-1:0] r);
    for (int d = 1; d <= int'(N); d++) begin
      if (r[(last + d) % N]) return (last + d) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 0;
      m_idx   <= 0;
      m_cnt   <= 0;
      m_last  <= N - 1;
    end else if (m_valid == 0) begin
      if (req != '0) begin
        m_idx   <= rr_pick(m_last, req);
        m_valid <= 1;
      end
    end else if (gnt_ack) begin
      m_last  <= m_idx;
      m_cnt   <= (m_cnt + 1) % 256;
      m_valid <= 0;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_valid", int'(gnt_valid), m_valid);
      check("cyc_cnt", int'(gnt_cnt), m_cnt);
      if (m_valid != 0) check("cyc_idx", int'(gnt_idx), m_idx);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Wait (bounded) for gnt_valid. Returns the number of falling edges waited.
  task automatic wait_valid(output int w);
    w = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      w = i;
      if (gnt_valid) break;
    end
    if (!gnt_valid) check("grant_timeout", 0, 1);
  endtask

  // Ack the current grant on the present cycle and confirm it drops.
  task automatic do_ack();
    #2 gnt_ack = 1'b1;
    @(negedge clk);
    check("ack_drop", int'(gnt_valid), 0);
    #2 gnt_ack = 1'b0;
  endtask

  task automatic grant_ack(input logic [N-1:0] r, input int exp_idx);
    int w;
    req = r;
    gnt_ack = 1'b0;
    wait_valid(w);
    check("grant_idx", int'(gnt_idx), exp_idx);
    check("grant_latency", w, 1);
    do_ack();
  endtask

  // Full reset pulse from a drive point. Outputs are checked before any edge.
  task automatic reset_pulse();
    req = '0;
    gnt_ack = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_valid", int'(gnt_valid), 0);
    check("rst_idx", int'(gnt_idx), 0);
    check("rst_cnt", int'(gnt_cnt), 0);
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int w;
    logic [N-1:0] onehot;

    // Reset asserted mid-cycle, no clock edge before the check.
    #3 rst = 1'b1;
    #1;
    check("rst0_valid", int'(gnt_valid), 0);
    check("rst0_idx", int'(gnt_idx), 0);
    check("rst0_cnt", int'(gnt_cnt), 0);
    chk_en = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;

    // Single request on index 5. Decoder output must be one-hot bit 5.
    req = 8'b0010_0000;
    wait_valid(w);
    check("single_latency", w, 1);
    check("single_idx", int'(gnt_idx), 5);
    onehot = '0;
    onehot[gnt_idx] = 1'b1;
    check("single_decode", int'(onehot), 32'h20);
    do_ack();
    check("single_cnt", int'(gnt_cnt), 1);

    // Rotation with all requesting, starting fresh: 0..7 then 0.
    reset_pulse();
    for (int i = 0; i <= 8; i++) grant_ack(8'hFF, i % 8);
    // last is now 0: 7, 0, 7.
    grant_ack(8'b1000_0001, 7);
    grant_ack(8'b1000_0001, 0);
    grant_ack(8'b1000_0001, 7);
    check("rot_cnt", int'(gnt_cnt), 12);

    // Sticky grant on index 3 while its request is withdrawn.
    req = 8'b0000_1000;
    wait_valid(w);
    check("sticky_idx0", int'(gnt_idx), 3);
    #2 req = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("sticky_valid", int'(gnt_valid), 1);
      check("sticky_idx", int'(gnt_idx), 3);
    end
    do_ack();
    check("sticky_cnt", int'(gnt_cnt), 13);

    // Ack pulsed in IDLE is ignored. The pointer stays at 3, so the next grant is 4.
    req = '0;
    gnt_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("idle_ack_cnt", int'(gnt_cnt), 13);
    check("idle_ack_valid", int'(gnt_valid), 0);
    #2 gnt_ack = 1'b0;
    grant_ack(8'hFF, 4);

    // Reset mid-grant on index 6.
    reset_pulse();
    req = 8'b0100_0000;
    wait_valid(w);
    check("mid_idx", int'(gnt_idx), 6);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", int'(gnt_valid), 0);
    check("mid_rst_cnt", int'(gnt_cnt), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    grant_ack(8'hFF, 0);

    // Count wrap: 256 acked grants return to 0, and the 257th gives 1.
    reset_pulse();
    for (int i = 0; i < 256; i++) grant_ack(8'hFF, i % 8);
    check("wrap_cnt0", int'(gnt_cnt), 0);
    grant_ack(8'hFF, 0);
    check("wrap_cnt1", int'(gnt_cnt), 1);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
